// File: rtl/sync_pkg.sv
// Shared types and helpers for the input debounce path.
package sync_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } debounce_state_t;

  localparam int DEBOUNCE_MAX_CYCLES = 255;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_debounce_cnt.sv
// Saturating up-counter with clear and limit flag; stops at LIMIT and never wraps.
// Latency: cnt updates one clock after clr/inc. No backpressure.
module debounce_cnt #(
  parameter int WIDTH = 3,
  parameter int LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt < LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt == LIM);

endmodule

// File: rtl/sync_debounce.sv
// Debounce + edge detect of a synchronized level; all outputs registered, one-cycle strobes.
// Latency: new level visible the cycle after the STABLE_CYCLES-th agreeing edge. No backpressure. Optional SYNC_DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt.
module sync_debounce
  import sync_pkg::*;
#(
  parameter int   STABLE_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync_in,
  output logic       level_out,
  output logic       rise_pulse,
  output logic       fall_pulse
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int CW = cnt_width(STABLE_CYCLES);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > DEBOUNCE_MAX_CYCLES) begin : g_bad_param
    $error("sync_debounce: STABLE_CYCLES out of range 2..255");
  end

  debounce_state_t state_q, state_d;
  logic level_q, level_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;
  logic cnt_clr, cnt_inc, at_limit;
  logic [CW-1:0] cnt;

  // Counter reaching STABLE_CYCLES-1 in CHECK_* means this edge is the last agreeing sample.
  debounce_cnt #(
    .WIDTH (CW),
    .LIMIT (STABLE_CYCLES - 1)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .cnt      (cnt),
    .at_limit (at_limit)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (sync_in) begin
          state_d = CHECK_HI;
          cnt_inc = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      CHECK_HI: begin
        if (!sync_in) begin
          state_d = STABLE_LO;
          cnt_clr = 1'b1;
        end else if (at_limit) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STABLE_HI: begin
        if (!sync_in) begin
          state_d = CHECK_LO;
          cnt_inc = 1'b1;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      CHECK_LO: begin
        if (sync_in) begin
          state_d = STABLE_HI;
          cnt_clr = 1'b1;
        end else if (at_limit) begin
          state_d = STABLE_LO;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = level_q ? STABLE_HI : STABLE_LO;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_LEVEL ? STABLE_HI : STABLE_LO;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic       abort;
  logic [7:0] glitch_q;

  assign abort = ((state_q == CHECK_HI) && !sync_in) ||
                 ((state_q == CHECK_LO) &&  sync_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      glitch_q <= 8'h00;
    end else if (abort && (glitch_q != 8'hFF)) begin
      glitch_q <= glitch_q + 8'h01;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Directed-vector bench for sync_debounce: default instance (4 cycles, reset low) and a
// (2 cycles, reset high) instance; glitch counter checked when SYNC_DEBOUNCE_GLITCH_CNT_EN is set.
module tb_sync_debounce;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic rst_a = 1'b1, sync_a = 1'b0, level_a, rise_a, fall_a;
  logic rst_b = 1'b1, sync_b = 1'b0, level_b, rise_b, fall_b;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_a, glitch_b;
`endif

  int checks   = 0;
  int failures = 0;

  sync_debounce #(.STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) u_dut_a (
    .clk        (tb_clk),
    .rst        (rst_a),
    .sync_in    (sync_a),
    .level_out  (level_a),
    .rise_pulse (rise_a),
    .fall_pulse (fall_a)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_a)
`endif
  );

  sync_debounce #(.STABLE_CYCLES(2), .RESET_LEVEL(1'b1)) u_dut_b (
    .clk        (tb_clk),
    .rst        (rst_b),
    .sync_in    (sync_b),
    .level_out  (level_b),
    .rise_pulse (rise_b),
    .fall_pulse (fall_b)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  initial begin
    int rises;

    // 1: reset with input high, then clean rise
    rst_a = 1'b1; sync_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("t1_rst_level", level_a, 0);
      check("t1_rst_rise", rise_a, 0);
      check("t1_rst_fall", fall_a, 0);
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("t1_rst_glitch", glitch_a, 0);
`endif
    rst_a = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("t1_pre_level", level_a, 0);
      check("t1_pre_rise", rise_a, 0);
    end
    step();
    check("t1_acc_level", level_a, 1);
    check("t1_acc_rise", rise_a, 1);
    check("t1_acc_fall", fall_a, 0);
    step();
    check("t1_post_rise", rise_a, 0);
    check("t1_post_level", level_a, 1);

    // 2: glitch on the last check cycle, then a clean rise
    rst_a = 1'b1; sync_a = 1'b0;
    step();
    rst_a = 1'b0;
    check("t2_rst_level", level_a, 0);
    sync_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_try1_rise", rise_a, 0);
    end
    sync_a = 1'b0;
    step();
    check("t2_glitch_rise", rise_a, 0);
    check("t2_glitch_level", level_a, 0);
    sync_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t2_try2_rise", rise_a, (i == 4) ? 1 : 0);
      check("t2_try2_level", level_a, (i == 4) ? 1 : 0);
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("t2_glitch_cnt", glitch_a, 1);
`endif

    // 3: toggling input never changes the level
    for (int i = 0; i < 20; i++) begin
      sync_a = (i % 2 == 0) ? 1'b0 : 1'b1;
      step();
      check("t3_level", level_a, 1);
      check("t3_fall", fall_a, 0);
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("t3_glitch_cnt", glitch_a, 11);
`endif

    // 4: fall followed immediately by rise, 4 cycles apart
    sync_a = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t4_fall", fall_a, (i == 4) ? 1 : 0);
      check("t4_level", level_a, (i == 4) ? 0 : 1);
    end
    sync_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t4_fall_clr", fall_a, 0);
      check("t4_rise", rise_a, (i == 4) ? 1 : 0);
    end
    check("t4_level_hi", level_a, 1);

    // 5: reset on the accepting edge wins
    rst_a = 1'b1; sync_a = 1'b0;
    step();
    rst_a = 1'b0; sync_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_pre_rise", rise_a, 0);
    end
    rst_a = 1'b1;
    step();
    check("t5_rst_level", level_a, 0);
    check("t5_rst_rise", rise_a, 0);
    rst_a = 1'b0; sync_a = 1'b0;
    step();
    check("t5_after_rise", rise_a, 0);
    check("t5_after_level", level_a, 0);

    // 6: reset-high instance, 2-cycle filter, glitch saturation
    rst_b = 1'b1; sync_b = 1'b1;
    step();
    check("t6_rst_level", level_b, 1);
    check("t6_rst_fall", fall_b, 0);
    rst_b = 1'b0; sync_b = 1'b0;
    step();
    check("t6_e1_level", level_b, 1);
    check("t6_e1_fall", fall_b, 0);
    step();
    check("t6_e2_level", level_b, 0);
    check("t6_e2_fall", fall_b, 1);
    rises = 0;
    for (int g = 1; g <= 300; g++) begin
      sync_b = 1'b1;
      step();
      rises += int'(rise_b);
      sync_b = 1'b0;
      step();
      rises += int'(rise_b);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      if (g == 254) check("t6_glitch_254", glitch_b, 254);
      if (g == 255) check("t6_glitch_255", glitch_b, 255);
`endif
    end
    check("t6_no_rise", rises, 0);
    check("t6_level_lo", level_b, 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("t6_glitch_sat", glitch_b, 255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
